// File: rtl/morra_sequencer_if.sv
// Datapath-side link of the morra sequencer.
// The manche evaluator (master) presents one result per manche on esito/esito_v.
// The sequencer (slave) returns a one-cycle dp_clear pulse that wipes the
// evaluator's previous-move and previous-winner memory.
//   esito_v  : result strobe, one cycle per manche
//   esito    : 00 invalid, 01 secondo wins, 10 primo wins, 11 draw
//   dp_clear : clear request back to the evaluator
interface morra_sequencer_if;
    logic       esito_v;
    logic [1:0] esito;
    logic       dp_clear;

    modport master (
        output esito_v,
        output esito,
        input  dp_clear
    );

    modport slave (
        input  esito_v,
        input  esito,
        output dp_clear
    );
endinterface

// File: rtl/morra_sequencer.sv
// Game-level controller for the morra cinese manche datapath.
// On inizio the game length is latched from the player inputs and the datapath
// memory is cleared; then each valid manche result is counted and the game ends
// on an early win (enough manches and a 2-win lead) or when the length is reached.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   inizio         : start/restart request (priority over results)
//   primo, secondo : player inputs, used only to configure the game length
//   dp             : datapath link (esito_v/esito in, dp_clear out)
//   in_gioco, fine : state flags
//   partita        : game result (00 none, 01 secondo, 10 primo, 11 draw)
//   count, max     : valid manches played and latched game length
// Optional feature: define MORRA_TIMEOUT_EN to end the game after TIMEOUT idle
// cycles in GIOCO; without it GIOCO waits indefinitely.
module morra_sequencer #(
    parameter int unsigned MIN_MANCHE = 4,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inizio,
    input  logic [1:0]       primo,
    input  logic [1:0]       secondo,
    morra_sequencer_if.slave dp,
    output logic             in_gioco,
    output logic             fine,
    output logic [1:0]       partita,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] max
);

    localparam logic [CNT_W-1:0] MinC = CNT_W'(MIN_MANCHE);

    typedef enum logic [1:0] {StIdle, StGioco, StFine} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] wins_p_q, wins_p_d;
    logic [CNT_W-1:0] wins_s_q, wins_s_d;
    logic [CNT_W-1:0] lead;
    logic [1:0]       partita_q, partita_d;
    logic             dp_clear_q, dp_clear_d;
    logic             valid;
    logic             end_hit;

`ifdef MORRA_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
    localparam logic [IdleW-1:0] TimeoutC = IdleW'(TIMEOUT);
    logic [IdleW-1:0] idle_q, idle_d;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            max_q      <= '0;
            wins_p_q   <= '0;
            wins_s_q   <= '0;
            partita_q  <= 2'b00;
            dp_clear_q <= 1'b0;
`ifdef MORRA_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            max_q      <= max_d;
            wins_p_q   <= wins_p_d;
            wins_s_q   <= wins_s_d;
            partita_q  <= partita_d;
            dp_clear_q <= dp_clear_d;
`ifdef MORRA_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    // Counter update and end-of-game detection on post-update values.
    always_comb begin
        count_d    = count_q;
        max_d      = max_q;
        wins_p_d   = wins_p_q;
        wins_s_d   = wins_s_q;
        partita_d  = partita_q;
        dp_clear_d = 1'b0;
        valid      = 1'b0;
        end_hit    = 1'b0;
        lead       = '0;
`ifdef MORRA_TIMEOUT_EN
        idle_d     = idle_q;
`endif
        if (inizio) begin
            max_d      = MinC + CNT_W'({primo, secondo});
            count_d    = '0;
            wins_p_d   = '0;
            wins_s_d   = '0;
            partita_d  = 2'b00;
            dp_clear_d = 1'b1;
`ifdef MORRA_TIMEOUT_EN
            idle_d     = '0;
`endif
        end else if (state_q == StGioco) begin
            valid = dp.esito_v && (dp.esito != 2'b00);
            if (valid) begin
                count_d = count_q + 1'b1;
                if (dp.esito == 2'b01) wins_s_d = wins_s_q + 1'b1;
                if (dp.esito == 2'b10) wins_p_d = wins_p_q + 1'b1;
            end
            lead = (wins_p_d >= wins_s_d) ? (wins_p_d - wins_s_d) : (wins_s_d - wins_p_d);
            // Only a counted manche can change the end condition.
            if (valid && (((count_d >= MinC) && (lead >= CNT_W'(2))) || (count_d == max_q))) begin
                end_hit = 1'b1;
            end
`ifdef MORRA_TIMEOUT_EN
            idle_d = valid ? '0 : idle_q + 1'b1;
            if (!valid && (idle_d == TimeoutC)) end_hit = 1'b1;
`endif
            if (end_hit) begin
                if (wins_p_d > wins_s_d)      partita_d = 2'b10;
                else if (wins_s_d > wins_p_d) partita_d = 2'b01;
                else                          partita_d = 2'b11;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (inizio) begin
            state_d = StGioco;
        end else begin
            unique case (state_q)
                StGioco: if (end_hit) state_d = StFine;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs, all taken straight from registers.
    always_comb begin
        in_gioco    = (state_q == StGioco);
        fine        = (state_q == StFine);
        partita     = partita_q;
        count       = count_q;
        max         = max_q;
        dp.dp_clear = dp_clear_q;
    end

endmodule

// File: doc/morra_sequencer.md
Name: morra_sequencer

Overview:
- Game-level controller for the morra cinese (rock-paper-scissors) manche datapath.
- On `inizio` it configures the game length from the player inputs and clears the datapath's previous-move memory.
- It then accepts one result per manche from the datapath, counts valid manches and wins, and declares the game winner.
- Sits between the top-level inputs and the manche evaluator; the evaluator owns move legality, this block owns game sequencing.

Parameters:
- MIN_MANCHE, 4, minimum valid manches before an early win can end the game; also the base of the game length.
- CNT_W, 5, width of the manche and win counters; must hold MIN_MANCHE+15.
- TIMEOUT, 16, idle cycles allowed in GIOCO before forced end (optional feature only).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- inizio  in  1  start/restart request, sampled on clk.
- primo  in  2  player-1 input; used only for configuration when inizio=1.
- secondo  in  2  player-2 input; used only for configuration when inizio=1.
- esito_v  in  1  datapath result strobe, one cycle per manche.
- esito  in  2  manche result: 00 invalid, 01 secondo wins, 10 primo wins, 11 draw.
- dp_clear  out  1  one-cycle pulse telling the datapath to clear previous-move/previous-winner memory.
- in_gioco  out  1  high while state is GIOCO.
- fine  out  1  high while state is FINE.
- partita  out  2  game result: 00 none, 01 secondo, 10 primo, 11 draw.
- count  out  CNT_W  valid manches played.
- max  out  CNT_W  game length latched at start.

Behaviour:
- Decided: one clock `clk`; `rst_n` asynchronous, active-low.
- Reset values:
  - state IDLE.
  - dp_clear=0, in_gioco=0, fine=0, partita=00.
  - count=0, max=0; internal wins_p/wins_s=0.
- States: IDLE, GIOCO, FINE. All outputs are registered.
- Start:
  - inizio=1 at an edge, from any state, causes:
    - max <= MIN_MANCHE + {primo,secondo} (zero-extended 4-bit concat; range 4..19 at default).
    - count, wins_p, wins_s <= 0; partita <= 00.
    - dp_clear <= 1 for exactly one cycle; state <= GIOCO.
  - inizio held high restarts every cycle: dp_clear stays high, no manche is accepted.
  - inizio has priority over esito_v on the same edge.
- GIOCO, esito_v=1, inizio=0:
  - esito=00: ignored; no counter change.
  - esito=01: count+1, wins_s+1.
  - esito=10: count+1, wins_p+1.
  - esito=11: count+1, no win change.
- End check, evaluated on the post-update values at the same edge:
  - Condition A: count >= MIN_MANCHE and |wins_p - wins_s| >= 2.
  - Condition B: count == max.
  - If A or B: state <= FINE and partita <= leader (10 primo, 01 secondo, 11 if equal).
  - The deciding manche and the fine assertion occur on the same edge; latency is 1 cycle from esito_v to fine.
- esito_v is ignored in IDLE and FINE; counters freeze.
- FINE holds partita, count and max until inizio or reset.
- count never exceeds max. Counters do not wrap.
- Reset mid-game returns immediately to IDLE with all outputs at reset values.

Optional Feature:
- Macro: MORRA_TIMEOUT_EN.
- Defined:
  - An idle counter increments each GIOCO cycle without a valid (esito!=00) esito_v.
  - The counter clears on a valid manche and on start.
  - Reaching TIMEOUT forces state <= FINE with partita set to the current leader (11 if equal), including the count==0 case.
- Undefined: no idle counter; GIOCO waits indefinitely.

Test Plan:
- Reset/start:
  - Stimulus: rst_n low, then inizio=1 with primo=10, secondo=11.
  - Response: after reset all outputs are 0. After the inizio edge: max=15, count=0, dp_clear=1 for one cycle, in_gioco=1.
- Early win:
  - Stimulus: primo=00, secondo=00 (max=4); results 10,10,11,10.
  - Response: at the 4th result edge, count=4, wins 3-0, fine=1, partita=10.
- Draw at max:
  - Stimulus: max=4; results 10,01,11,11.
  - Response: count=4 reaches max, fine=1, partita=11.
- Invalid and spurious strobes:
  - Stimulus: esito=00 strobes in GIOCO; esito_v pulses in FINE.
  - Response: count and partita unchanged.
- Restart:
  - Stimulus: mid-game inizio=1 together with esito_v=1, esito=10.
  - Response: the manche is not counted; count=0, new max latched, dp_clear pulse.
- Timeout (MORRA_TIMEOUT_EN):
  - Stimulus: one result 01, then 16 idle cycles.
  - Response: fine=1, partita=01.
